// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128 key schedule: one expansion step per cycle into an 11-entry round-key file,
// sequenced by start/busy/done, with a zero-latency indexed read port.
module aes_key_schedule_ctrl (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_key,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_keys_valid,
  input  logic [3:0]   i_rd_idx,
  output logic [127:0] o_rd_key
);

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] w_idx;
    w_idx = {~b, 3'b000};
    return SBOX[w_idx +: 8];
  endfunction

  state_e         r_state, w_state_next;
  logic [127:0]   r_rk [0:10];
  logic [127:0]   r_work;
  logic [3:0]     r_round;
  logic [7:0]     r_rcon;
  logic           r_keys_valid;

  logic           w_load, w_step;
  logic [31:0]    w_w0, w_w1, w_w2, w_w3, w_rot, w_t, w_n0, w_n1, w_n2, w_n3;
  logic [127:0]   w_next;
  logic [7:0]     w_rcon_next;

  assign w_w0  = r_work[127:96];
  assign w_w1  = r_work[95:64];
  assign w_w2  = r_work[63:32];
  assign w_w3  = r_work[31:0];
  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_t   = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                 ^ {r_rcon, 24'h0};
  assign w_n0  = w_w0 ^ w_t;
  assign w_n1  = w_w1 ^ w_n0;
  assign w_n2  = w_w2 ^ w_n1;
  assign w_n3  = w_w3 ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_state_next = StExpand;
        end
      end
      StExpand: begin
        o_busy = 1'b1;
        w_step = 1'b1;
        if (r_round == 4'd10) w_state_next = StDone;
      end
      StDone: begin
        o_done = 1'b1;
        if (i_start) begin
          w_load       = 1'b1;
          w_state_next = StExpand;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_work       <= '0;
      r_round      <= '0;
      r_rcon       <= 8'h01;
      r_keys_valid <= 1'b0;
      for (int i = 0; i <= 10; i++) r_rk[i] <= '0;
    end else if (w_load) begin
      r_rk[0]      <= i_key;
      r_work       <= i_key;
      r_round      <= 4'd1;
      r_rcon       <= 8'h01;
      r_keys_valid <= 1'b0;
    end else if (w_step) begin
      for (int i = 1; i <= 10; i++) begin
        if (r_round == 4'(i)) r_rk[i] <= w_next;
      end
      r_work  <= w_next;
      r_round <= r_round + 4'd1;
      r_rcon  <= w_rcon_next;
      if (r_round == 4'd10) r_keys_valid <= 1'b1;
    end
  end

  assign o_keys_valid = r_keys_valid;

  always_comb begin
    o_rd_key = '0;
    if (r_keys_valid) begin
      for (int i = 0; i <= 10; i++) begin
        if (i_rd_idx == 4'(i)) o_rd_key = r_rk[i];
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Randomised bench for aes_key_schedule_ctrl against a word-level FIPS-197 key-expansion model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         i_rst, i_start;
  logic [127:0] i_key;
  logic [3:0]   i_rd_idx;
  logic         o_busy, o_done, o_keys_valid;
  logic [127:0] o_rd_key;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_m [0:255];
  logic [127:0] exp_rk [0:10];

  aes_key_schedule_ctrl dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_key        (i_key),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_keys_valid (o_keys_valid),
    .i_rd_idx     (i_rd_idx),
    .o_rd_key     (o_rd_key)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    logic       hi;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa ^= 8'h1b;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the accepting edge (cycle 1).
  task automatic do_start(input logic [127:0] k);
    i_start = 1'b1;
    i_key   = k;
    @(negedge clk);
    i_start = 1'b0;
    i_key   = rand128();
  endtask

  // Cycle c is the c-th negedge after the start cycle; samples, then drives.
  task automatic run_cycles(input int n, input int start_at, input logic [127:0] k2,
                            input int rst_at, output int first_done, output int n_done,
                            output int n_busy);
    first_done = 0;
    n_done     = 0;
    n_busy     = 0;
    for (int c = 1; c <= n; c++) begin
      if (o_done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (o_busy) n_busy++;
      i_start = (c == start_at);
      i_key   = (c == start_at) ? k2 : rand128();
      i_rst   = (c == rst_at);
      @(negedge clk);
    end
    i_start = 1'b0;
    i_rst   = 1'b0;
  endtask

  task automatic check_all_keys(input bit valid);
    for (int i = 0; i < 16; i++) begin
      i_rd_idx = 4'(i);
      #1;
      check_eq($sformatf("rk[%0d]", i), o_rd_key, (valid && i <= 10) ? exp_rk[i] : 128'h0);
      @(negedge clk);
    end
  endtask

  task automatic full_run(input string name, input logic [127:0] k);
    int fd, nd, nb;
    compute_model(k);
    do_start(k);
    run_cycles(12, -1, '0, -1, fd, nd, nb);
    check_eq({name, " done_cycle"}, 128'(fd), 128'd11);
    check_eq({name, " done_count"}, 128'(nd), 128'd1);
    check_eq({name, " busy_cycles"}, 128'(nb), 128'd10);
    check_eq({name, " keys_valid"}, 128'(o_keys_valid), 128'd1);
    check_eq({name, " busy_idle"}, 128'(o_busy), 128'd0);
    check_all_keys(1'b1);
  endtask

  initial begin
    int fd, nd, nb;
    logic [127:0] ka, kb;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_key    = '0;
    i_rd_idx = '0;
    build_sbox();
    @(negedge clk);
    @(negedge clk);
    check_eq("reset busy", 128'(o_busy), 128'd0);
    check_eq("reset done", 128'(o_done), 128'd0);
    check_eq("reset keys_valid", 128'(o_keys_valid), 128'd0);
    check_eq("reset rd_key", o_rd_key, 128'h0);
    i_rst = 1'b0;
    @(negedge clk);

    // FIPS-197 vector
    compute_model(128'h000102030405060708090a0b0c0d0e0f);
    check_eq("model fips rk1", exp_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check_eq("model fips rk10", exp_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    full_run("fips", 128'h000102030405060708090a0b0c0d0e0f);
    i_rd_idx = 4'd1;
    #1 check_eq("fips rd1", o_rd_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    i_rd_idx = 4'd10;
    #1 check_eq("fips rd10", o_rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    @(negedge clk);

    // Appendix A vector
    full_run("appA", 128'h2b7e151628aed2a6abf7158809cf4f3c);
    i_rd_idx = 4'd1;
    #1 check_eq("appA rd1", o_rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    i_rd_idx = 4'd10;
    #1 check_eq("appA rd10", o_rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);

    // Start while busy is ignored
    ka = rand128();
    kb = rand128();
    compute_model(ka);
    do_start(ka);
    run_cycles(14, 4, kb, -1, fd, nd, nb);
    check_eq("busy_start done_cycle", 128'(fd), 128'd11);
    check_eq("busy_start done_count", 128'(nd), 128'd1);
    check_all_keys(1'b1);

    // Reset in the middle of expansion
    do_start(rand128());
    run_cycles(5, -1, '0, 5, fd, nd, nb);
    check_eq("rst busy", 128'(o_busy), 128'd0);
    check_eq("rst keys_valid", 128'(o_keys_valid), 128'd0);
    check_eq("rst done", 128'(o_done), 128'd0);
    run_cycles(12, -1, '0, -1, fd, nd, nb);
    check_eq("rst no_done", 128'(nd), 128'd0);
    check_all_keys(1'b0);
    full_run("after_rst", rand128());

    // Back-to-back schedules via start in the done cycle
    ka = rand128();
    kb = rand128();
    compute_model(ka);
    do_start(ka);
    run_cycles(11, 11, kb, -1, fd, nd, nb);
    check_eq("b2b first done_cycle", 128'(fd), 128'd11);
    check_eq("b2b keys_valid_drop", 128'(o_keys_valid), 128'd0);
    check_eq("b2b busy", 128'(o_busy), 128'd1);
    check_eq("b2b done_low", 128'(o_done), 128'd0);
    i_rd_idx = 4'd0;
    #1 check_eq("b2b rd_invalid", o_rd_key, 128'h0);
    compute_model(kb);
    run_cycles(12, -1, '0, -1, fd, nd, nb);
    check_eq("b2b second done_cycle", 128'(fd), 128'd11);
    check_eq("b2b second done_count", 128'(nd), 128'd1);
    check_all_keys(1'b1);

    for (int r = 0; r < 4; r++) full_run($sformatf("rand%0d", r), rand128());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
